// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the 8n1 UART blocks.
//   uart_state_t  receiver framing states (also exported on the debug port)
//   SAMPLE_T0..T2 x16 tick values at which the line is sampled for a bit
//   LAST_TICK     final x16 tick of a bit period
//   DATA_BITS     payload bits per frame
//   majority3     2-of-3 vote used to filter line noise
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_t;

    localparam logic [3:0] SAMPLE_T0 = 4'd7;
    localparam logic [3:0] SAMPLE_T1 = 4'd8;
    localparam logic [3:0] SAMPLE_T2 = 4'd9;
    localparam logic [3:0] LAST_TICK = 4'd15;
    localparam int         DATA_BITS = 8;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/rx_fifo.sv
// rx_fifo: first-word fall-through FIFO holding received bytes.
//   clk, rst_n   clock, asynchronous active-low reset
//   push, wdata  write strobe and data
//   pop          read strobe; ignored while empty
//   rdata        head entry, valid while not_empty (0 when empty)
//   not_empty    at least one entry stored
//   half_full    count >= DEPTH/2
//   full         count == DEPTH
//   overflow     one-clk pulse when a push is dropped (full, no pop)
// A push and pop in the same clk while full both take effect, so the
// writer is never refused when the reader frees a slot in that clk.
module rx_fifo #(
    parameter int WIDTH      = 8,
    parameter int LOG2_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             not_empty,
    output logic             half_full,
    output logic             full,
    output logic             overflow
);
    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam logic [LOG2_DEPTH:0] CNT_FULL = (LOG2_DEPTH+1)'(DEPTH);
    localparam logic [LOG2_DEPTH:0] CNT_HALF = (LOG2_DEPTH+1)'(DEPTH / 2);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [LOG2_DEPTH-1:0] wr_ptr;
    logic [LOG2_DEPTH-1:0] rd_ptr;
    logic [LOG2_DEPTH:0]   count;
    logic                  do_push;
    logic                  do_pop;

    assign not_empty = (count != '0);
    assign full      = (count == CNT_FULL);
    assign half_full = (count >= CNT_HALF);
    assign do_pop    = pop && not_empty;
    assign do_push   = push && (!full || do_pop);
    assign overflow  = push && full && !pop;
    assign rdata     = not_empty ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + LOG2_DEPTH'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + LOG2_DEPTH'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (LOG2_DEPTH+1)'(1);
                2'b01:   count <= count - (LOG2_DEPTH+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rx_uart.sv
// rx_uart: 8n1 UART receiver with x16 oversampling and a receive FIFO.
//   clk, rstN      clock, asynchronous active-low reset
//   x16BaudStrobe  one-clk strobe at 16x baud; each strobe is one tick
//   serialIn       asynchronous serial line, idles high
//   read           pop strobe for the FIFO head
//   dataOut        FIFO head byte, valid while dataPresent
//   dataPresent    FIFO not empty
//   halfFull, full FIFO level flags
//   frameError     one-clk pulse when a stop bit is sampled low
//   overrun        one-clk pulse when a good byte is dropped (FIFO full)
//   stateDbg       current framing state
// Host handshake: dataPresent is valid, read is ready; a byte moves on
// every clk where both are high, and read with dataPresent low does nothing.
module rx_uart
    import uart_pkg::*;
#(
    parameter int LOG2_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic        x16BaudStrobe,
    input  logic        serialIn,
    input  logic        read,
    output logic [7:0]  dataOut,
    output logic        dataPresent,
    output logic        halfFull,
    output logic        full,
    output logic        frameError,
    output logic        overrun,
    output uart_state_t stateDbg
);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic                 sync_q1;
    logic                 rx_s;
    uart_state_t          state;
    uart_state_t          state_nxt;
    logic [3:0]           tick;
    logic [2:0]           bit_cnt;
    logic                 samp0;
    logic                 samp1;
    logic                 bit_val;
    logic [DATA_BITS-1:0] shreg;
    logic                 tick_clr;
    logic                 bit_cnt_clr;
    logic                 bit_cnt_inc;
    logic                 shift_en;
    logic                 push_set;
    logic                 ferr_set;
    logic                 push_q;
    logic                 frame_err_q;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            sync_q1 <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            sync_q1 <= serialIn;
            rx_s    <= sync_q1;
        end
    end

    // The third vote is the live rxS, so bit_val is only meaningful on the
    // strobe at SAMPLE_T2.
    assign bit_val  = majority3(samp0, samp1, rx_s);
    assign stateDbg = state;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        tick_clr    = 1'b0;
        bit_cnt_clr = 1'b0;
        bit_cnt_inc = 1'b0;
        shift_en    = 1'b0;
        push_set    = 1'b0;
        ferr_set    = 1'b0;
        if (x16BaudStrobe) begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state_nxt = START;
                        tick_clr  = 1'b1;
                    end
                end
                START: begin
                    if (tick == SAMPLE_T2 && bit_val) begin
                        state_nxt = IDLE;
                    end else if (tick == LAST_TICK) begin
                        state_nxt   = DATA;
                        bit_cnt_clr = 1'b1;
                    end
                end
                DATA: begin
                    if (tick == SAMPLE_T2) begin
                        shift_en = 1'b1;
                    end
                    if (tick == LAST_TICK) begin
                        if (bit_cnt == LAST_BIT) begin
                            state_nxt = STOP;
                        end else begin
                            bit_cnt_inc = 1'b1;
                        end
                    end
                end
                STOP: begin
                    // Leaving at mid stop bit gives half a bit of slack to
                    // catch the next start edge on back-to-back frames.
                    if (tick == SAMPLE_T2) begin
                        if (bit_val) begin
                            push_set  = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            ferr_set  = 1'b1;
                            state_nxt = BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            tick        <= '0;
            bit_cnt     <= '0;
            samp0       <= 1'b0;
            samp1       <= 1'b0;
            shreg       <= '0;
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (tick_clr) begin
                tick <= '0;
            end else if (x16BaudStrobe) begin
                tick <= tick + 4'd1;
            end
            if (x16BaudStrobe && tick == SAMPLE_T0) begin
                samp0 <= rx_s;
            end
            if (x16BaudStrobe && tick == SAMPLE_T1) begin
                samp1 <= rx_s;
            end
            if (bit_cnt_clr) begin
                bit_cnt <= '0;
            end else if (bit_cnt_inc) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
            // LSB arrives first, so shift in from the top.
            if (shift_en) begin
                shreg <= {bit_val, shreg[DATA_BITS-1:1]};
            end
            push_q      <= push_set;
            frame_err_q <= ferr_set;
        end
    end

    assign frameError = frame_err_q;

    // shreg is stable until the next frame's data bits, so it can be
    // written in the clk after the stop-bit decision.
    rx_fifo #(
        .WIDTH      (DATA_BITS),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rstN),
        .push      (push_q),
        .wdata     (shreg),
        .pop       (read),
        .rdata     (dataOut),
        .not_empty (dataPresent),
        .half_full (halfFull),
        .full      (full),
        .overflow  (overrun)
    );

endmodule

// File: tb/tb_rx_uart.sv
// tb_rx_uart: self-checking bench for rx_uart.
// Frames are driven bit by bit in units of x16 strobes. A queue models the
// receive FIFO contents; a per-cycle compare process checks the status
// outputs against it, except during each stop-bit window, where error
// pulses are counted and checked when the window closes.
module tb_rx_uart;
    import uart_pkg::*;

    localparam int LOG2_DEPTH = 4;
    localparam int DEPTH      = 1 << LOG2_DEPTH;

    logic        clk           = 1'b0;
    logic        rstN          = 1'b1;
    logic        x16BaudStrobe = 1'b0;
    logic        serialIn      = 1'b1;
    logic        read          = 1'b0;
    logic [7:0]  dataOut;
    logic        dataPresent;
    logic        halfFull;
    logic        full;
    logic        frameError;
    logic        overrun;
    uart_state_t state_dbg;

    int         checks  = 0;
    int         errors  = 0;
    int         div     = 16;
    int         div_cnt = 0;
    bit         cmp_en  = 1'b0;
    bit         settle  = 1'b0;
    int         fe_seen = 0;
    int         ov_seen = 0;
    logic [7:0] exp_q[$];

    rx_uart #(.LOG2_DEPTH(LOG2_DEPTH)) dut (
        .clk           (clk),
        .rstN          (rstN),
        .x16BaudStrobe (x16BaudStrobe),
        .serialIn      (serialIn),
        .read          (read),
        .dataOut       (dataOut),
        .dataPresent   (dataPresent),
        .halfFull      (halfFull),
        .full          (full),
        .frameError    (frameError),
        .overrun       (overrun),
        .stateDbg      (state_dbg)
    );

    // ---------------- clock / strobe ----------------
    always #5 clk = ~clk;

    initial forever begin
        @(negedge clk);
        if (div_cnt >= div - 1) begin
            div_cnt       = 0;
            x16BaudStrobe = 1'b1;
        end else begin
            div_cnt       = div_cnt + 1;
            x16BaudStrobe = 1'b0;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (rstN && cmp_en) begin
            if (settle) begin
                if (frameError === 1'b1) fe_seen = fe_seen + 1;
                if (overrun === 1'b1)    ov_seen = ov_seen + 1;
            end else begin
                check("frameError quiet", frameError, 0);
                check("overrun quiet", overrun, 0);
                check("dataPresent", dataPresent, exp_q.size() != 0);
                check("halfFull", halfFull, exp_q.size() >= DEPTH / 2);
                check("full", full, exp_q.size() == DEPTH);
                if (exp_q.size() != 0) check("dataOut", dataOut, exp_q[0]);
            end
        end
    end

    initial begin
        repeat (90000) @(posedge clk);
        errors = errors + 1;
        $display("FAIL watchdog: simulation did not finish in 90000 clk");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_strobes(input int n);
        int seen = 0;
        while (seen < n) begin
            @(posedge clk);
            #1;
            if (x16BaudStrobe) seen = seen + 1;
        end
    endtask

    // One bit period is 16 strobes; with flip the line is inverted for
    // the single strobe that lands on tick 8 when the frame started right
    // after a strobe at a divider of 3 or more.
    task automatic drive_bit(input logic v, input bit flip);
        serialIn = v;
        if (flip) begin
            wait_strobes(9);
            serialIn = ~v;
            wait_strobes(1);
            serialIn = v;
            wait_strobes(6);
        end else begin
            wait_strobes(16);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_val, input bit flip);
        int fe0;
        int ov0;
        bit exp_ov;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i], flip);
        settle = 1'b1;
        fe0    = fe_seen;
        ov0    = ov_seen;
        drive_bit(stop_val, 1'b0);
        wait_clks(3);
        exp_ov = 1'b0;
        if (stop_val) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(b);
            else exp_ov = 1'b1;
        end
        check("frameError pulses", fe_seen - fe0, stop_val ? 0 : 1);
        check("overrun pulses", ov_seen - ov0, exp_ov);
        settle = 1'b0;
    endtask

    task automatic do_read_now();
        read = 1'b1;
        @(posedge clk);
        #1;
        read = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
    endtask

    task automatic do_read();
        @(posedge clk);
        #1;
        do_read_now();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit         ok;
        logic [7:0] e;
        logic [7:0] rb;
        logic       rs;

        // reset
        #1 rstN = 1'b0;
        #2;
        check("reset dataPresent", dataPresent, 0);
        check("reset dataOut", dataOut, 0);
        check("reset halfFull", halfFull, 0);
        check("reset full", full, 0);
        check("reset frameError", frameError, 0);
        check("reset overrun", overrun, 0);
        check("reset state", state_dbg, IDLE);
        repeat (3) @(posedge clk);
        #1 rstN = 1'b1;
        cmp_en = 1'b1;
        wait_clks(4);

        // back-to-back frames, 16 clk per strobe
        div = 16;
        wait_strobes(2);
        send_frame(8'hA5, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0);
        check("b2b first", dataOut, 8'hA5);
        do_read();
        check("b2b second", dataOut, 8'h3C);
        do_read();
        check("b2b drained", dataPresent, 0);

        // 4-strobe glitch from idle
        wait_strobes(1);
        serialIn = 1'b0;
        wait_strobes(4);
        check("glitch in START", state_dbg, START);
        serialIn = 1'b1;
        wait_strobes(32);
        check("glitch back to IDLE", state_dbg, IDLE);
        check("glitch no data", dataPresent, 0);

        // framing error, held-low line, recovery
        send_frame(8'h55, 1'b0, 1'b0);
        serialIn = 1'b0;
        wait_strobes(48);
        check("held low BREAK", state_dbg, BREAK);
        serialIn = 1'b1;
        wait_strobes(16);
        check("break released", state_dbg, IDLE);
        send_frame(8'h01, 1'b1, 1'b0);
        check("after break byte", dataOut, 8'h01);
        do_read();

        // tick-8 inversions on every data bit
        wait_strobes(1);
        send_frame(8'h96, 1'b1, 1'b1);
        check("majority byte", dataOut, 8'h96);
        do_read();

        // fill 16, overrun on the 17th
        div = 4;
        for (int i = 0; i < 17; i++) begin
            send_frame(8'(i), 1'b1, 1'b0);
            if (i == 6)  check("halfFull at 7", halfFull, 0);
            if (i == 7)  check("halfFull at 8", halfFull, 1);
            if (i == 14) check("full at 15", full, 0);
            if (i == 15) check("full at 16", full, 1);
        end
        check("overrun kept head", dataOut, 8'h00);
        for (int j = 0; j < 16; j++) begin
            check("fill drain", dataOut, j);
            do_read();
        end
        check("fill empty", dataPresent, 0);

        // full FIFO, read in the push clk
        div = 2;
        for (int i = 0; i < 16; i++) send_frame(8'(8'h20 + i), 1'b1, 1'b0);
        div = 4;
        fork
            send_frame(8'h77, 1'b1, 1'b0);
            begin
                ok = 1'b0;
                for (int n = 0; n < 5000; n++) begin
                    @(posedge clk);
                    #1;
                    if (state_dbg == STOP) begin
                        ok = 1'b1;
                        break;
                    end
                end
                check("reach STOP", ok, 1);
                ok = 1'b0;
                for (int n = 0; n < 500; n++) begin
                    if (state_dbg == IDLE) begin
                        ok = 1'b1;
                        break;
                    end
                    @(posedge clk);
                    #1;
                end
                check("reach push clk", ok, 1);
                do_read_now();
            end
        join
        check("simultaneous full", full, 1);
        for (int j = 0; j < 16; j++) begin
            e = (j < 15) ? 8'(8'h21 + j) : 8'h77;
            check("simultaneous drain", dataOut, e);
            do_read();
        end

        // reset in the middle of DATA
        send_frame(8'hC3, 1'b1, 1'b0);
        wait_strobes(1);
        serialIn = 1'b0;
        wait_strobes(16);
        serialIn = 1'b1;
        wait_strobes(16);
        serialIn = 1'b0;
        wait_strobes(16);
        serialIn = 1'b1;
        wait_strobes(8);
        check("mid DATA", state_dbg, DATA);
        #2 rstN = 1'b0;
        #1;
        check("async dataPresent", dataPresent, 0);
        check("async dataOut", dataOut, 0);
        check("async halfFull", halfFull, 0);
        check("async full", full, 0);
        check("async frameError", frameError, 0);
        check("async overrun", overrun, 0);
        check("async state", state_dbg, IDLE);
        exp_q.delete();
        serialIn = 1'b1;
        wait_clks(3);
        rstN = 1'b1;
        wait_strobes(20);
        send_frame(8'hF0, 1'b1, 1'b0);
        check("post reset byte", dataOut, 8'hF0);
        do_read();

        // randomized frames, dividers, errors and reads
        for (int k = 0; k < 12; k++) begin
            div = $urandom_range(1, 4);
            wait_strobes($urandom_range(1, 20));
            rb = 8'($urandom);
            rs = ($urandom_range(0, 5) != 0);
            send_frame(rb, rs, 1'b0);
            if (!rs) begin
                serialIn = 1'b0;
                wait_strobes(20);
                serialIn = 1'b1;
                wait_strobes(16);
            end
            repeat ($urandom_range(0, 2)) do_read();
        end
        for (int j = 0; j < DEPTH && exp_q.size() != 0; j++) do_read();
        wait_clks(2);
        check("final empty", dataPresent, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
